// File: rtl/lsu_stage.sv
`default_nettype none
// ============================================================================
// lsu_stage : three-state load/store unit between execute and writeback
// Rev 1.0
// ============================================================================

// Normally supplied by defs.v; this fallback keeps the file self-contained.
`ifndef MEM_SIZE
`define MEM_SIZE 32'h0000_1000
`endif

module lsu_stage (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_rd,
  output logic [31:0] o_ram_addr,
  output logic [2:0]  o_ram_insize,
  output logic        o_ram_insign,
  output logic [2:0]  o_ram_outsize,
  output logic [31:0] o_ram_data,
  input  logic [31:0] i_ram_data,
  input  logic        i_stall,
  output logic        o_done,
  output logic        o_wb_valid,
  output logic [4:0]  o_wb_rd,
  output logic [31:0] o_wb_data,
  output logic        o_exc,
  output logic [31:0] o_badaddr
);

  localparam logic [32:0] c_mem_limit = 33'(`MEM_SIZE);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [4:0]  rd_q;
  logic        exc_q;
  logic [31:0] wb_data_q;

  logic        w_accept;
  logic [2:0]  w_req_size;
  logic        w_misaligned;
  logic [32:0] w_req_end;
  logic        w_legal;
  logic [2:0]  w_size_q;
  logic        w_is_load_q;

  function automatic logic [2:0] op_size(input logic [2:0] op);
    case (op)
      3'd0, 3'd3, 3'd5: op_size = 3'd1;
      3'd1, 3'd4, 3'd6: op_size = 3'd2;
      default:          op_size = 3'd4;
    endcase
  endfunction

  assign o_ready  = (state_q == S_IDLE) && !i_rst;
  assign w_accept = i_valid && o_ready;

  // Range check is done in 33 bits so an access near 2^32 cannot wrap to a legal address.
  assign w_req_size   = op_size(i_op);
  assign w_misaligned = ((w_req_size == 3'd2) && i_addr[0]) ||
                        ((w_req_size == 3'd4) && (i_addr[1:0] != 2'b00));
  assign w_req_end    = {1'b0, i_addr} + {30'd0, w_req_size};
  assign w_legal      = !w_misaligned && (w_req_end <= c_mem_limit);

  assign w_size_q    = op_size(op_q);
  assign w_is_load_q = (op_q <= 3'd4);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      op_q      <= 3'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      rd_q      <= 5'd0;
      exc_q     <= 1'b0;
      wb_data_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (w_accept) begin
        op_q      <= i_op;
        addr_q    <= i_addr;
        wdata_q   <= i_wdata;
        rd_q      <= i_rd;
        exc_q     <= !w_legal;
        wb_data_q <= 32'd0;
      end else if ((state_q == S_ACCESS) && w_is_load_q) begin
        wb_data_q <= i_ram_data;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    o_ram_insize  = 3'd0;
    o_ram_insign  = 1'b0;
    o_ram_outsize = 3'd0;
    o_done        = 1'b0;
    o_wb_valid    = 1'b0;
    o_exc         = 1'b0;
    o_badaddr     = 32'd0;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          state_d = w_legal ? S_ACCESS : S_RESP;
        end
      end
      S_ACCESS: begin
        state_d = S_RESP;
        if (w_is_load_q) begin
          o_ram_insize = w_size_q;
          o_ram_insign = (op_q <= 3'd2);
        end else begin
          o_ram_outsize = w_size_q;
        end
      end
      S_RESP: begin
        o_done     = 1'b1;
        o_wb_valid = w_is_load_q && !exc_q;
        o_exc      = exc_q;
        o_badaddr  = exc_q ? addr_q : 32'd0;
        if (!i_stall) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_ram_addr = addr_q;
  assign o_ram_data = wdata_q;
  assign o_wb_rd    = rd_q;
  assign o_wb_data  = wb_data_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu_stage.sv
`default_nettype none
// ============================================================================
// tb_lsu_stage : directed vector bench for lsu_stage with a big-endian RAM model
// Rev 1.0
// ============================================================================

`ifndef MEM_SIZE
`define MEM_SIZE 32'h0000_1000
`endif

module tb_lsu_stage;

  localparam int MEMB = int'(`MEM_SIZE);

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [2:0]  i_op = 3'd0;
  logic [31:0] i_addr = 32'd0;
  logic [31:0] i_wdata = 32'd0;
  logic [4:0]  i_rd = 5'd0;
  logic [31:0] o_ram_addr;
  logic [2:0]  o_ram_insize;
  logic        o_ram_insign;
  logic [2:0]  o_ram_outsize;
  logic [31:0] o_ram_data;
  logic [31:0] ram_rd;
  logic        i_stall = 1'b0;
  logic        o_done;
  logic        o_wb_valid;
  logic [4:0]  o_wb_rd;
  logic [31:0] o_wb_data;
  logic        o_exc;
  logic [31:0] o_badaddr;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int wr_cycles = 0;

  logic [7:0] mem [MEMB] = '{default: 8'h00};

  lsu_stage dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_op         (i_op),
    .i_addr       (i_addr),
    .i_wdata      (i_wdata),
    .i_rd         (i_rd),
    .o_ram_addr   (o_ram_addr),
    .o_ram_insize (o_ram_insize),
    .o_ram_insign (o_ram_insign),
    .o_ram_outsize(o_ram_outsize),
    .o_ram_data   (o_ram_data),
    .i_ram_data   (ram_rd),
    .i_stall      (i_stall),
    .o_done       (o_done),
    .o_wb_valid   (o_wb_valid),
    .o_wb_rd      (o_wb_rd),
    .o_wb_data    (o_wb_data),
    .o_exc        (o_exc),
    .o_badaddr    (o_badaddr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (o_ram_outsize != 3'd0) wr_cycles <= wr_cycles + 1;

  // RAM write side: big-endian, committed at the clock edge
  always @(posedge clk) begin : ram_wr
    logic [32:0] a;
    logic [31:0] wd;
    if (o_ram_outsize != 3'd0) begin
      for (int b = 0; b < 4; b++) begin
        if (b < int'(o_ram_outsize)) begin
          a  = {1'b0, o_ram_addr} + 33'(b);
          wd = o_ram_data >> (8 * (int'(o_ram_outsize) - 1 - b));
          if (a < 33'(MEMB)) mem[int'(a[31:0])] <= wd[7:0];
        end
      end
    end
  end

  // RAM read side: combinational, big-endian, with sign/zero extension
  logic [31:0] raw;
  logic [32:0] ra;
  always_comb begin
    raw    = 32'd0;
    ra     = 33'd0;
    ram_rd = 32'd0;
    for (int b = 0; b < 4; b++) begin
      if (b < int'(o_ram_insize)) begin
        ra  = {1'b0, o_ram_addr} + 33'(b);
        raw = {raw[23:0], (ra < 33'(MEMB)) ? mem[int'(ra[31:0])] : 8'h00};
      end
    end
    case (o_ram_insize)
      3'd1: ram_rd = o_ram_insign ? {{24{raw[7]}}, raw[7:0]} : {24'd0, raw[7:0]};
      3'd2: ram_rd = o_ram_insign ? {{16{raw[15]}}, raw[15:0]} : {16'd0, raw[15:0]};
      3'd4: ram_rd = raw;
      default: ram_rd = 32'd0;
    endcase
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        exc;
    logic        wbv;
    logic [31:0] data;   // load result, or faulting address when exc=1
    int          writes;
  } vec_t;

  vec_t vecs [16];

  function automatic logic [2:0] exp_size(input logic [2:0] op);
    if (op == 3'd0 || op == 3'd3 || op == 3'd5) return 3'd1;
    if (op == 3'd1 || op == 3'd4 || op == 3'd6) return 3'd2;
    return 3'd4;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Presents a request and returns #1 after the edge where it was accepted.
  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] rd, output int t);
    int n;
    i_valid = 1'b1;
    i_op    = op;
    i_addr  = addr;
    i_wdata = wdata;
    i_rd    = rd;
    n = 0;
    @(negedge clk);
    while (!o_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!o_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: o_ready=%b after %0d cycles, expected 1", o_ready, n);
    end
    @(posedge clk);
    #1;
    t = cyc;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int t;
    int w0;
    int n;
    w0 = wr_cycles;
    issue(v.op, v.addr, v.wdata, v.rd, t);
    i_valid = 1'b0;
    if (v.exc) begin
      chk($sformatf("v%0d_exc_noram", idx), {26'd0, o_ram_insize, o_ram_outsize}, 32'd0);
    end else begin
      chk($sformatf("v%0d_ram_addr", idx), o_ram_addr, v.addr);
      chk($sformatf("v%0d_ram_insign", idx), o_ram_insign, (v.op <= 3'd2));
      if (v.op >= 3'd5) begin
        chk($sformatf("v%0d_outsize", idx), o_ram_outsize, exp_size(v.op));
        chk($sformatf("v%0d_insize", idx), o_ram_insize, 32'd0);
        chk($sformatf("v%0d_ram_data", idx), o_ram_data, v.wdata);
      end else begin
        chk($sformatf("v%0d_insize", idx), o_ram_insize, exp_size(v.op));
        chk($sformatf("v%0d_outsize", idx), o_ram_outsize, 32'd0);
      end
      chk($sformatf("v%0d_access_done", idx), o_done, 32'd0);
      n = 0;
      while (!o_done && n < 5) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk($sformatf("v%0d_resp_latency", idx), n, 32'd1);
    end
    chk($sformatf("v%0d_done", idx), o_done, 32'd1);
    chk($sformatf("v%0d_wb_valid", idx), o_wb_valid, v.wbv);
    chk($sformatf("v%0d_exc", idx), o_exc, v.exc);
    chk($sformatf("v%0d_badaddr", idx), o_badaddr, v.exc ? v.data : 32'd0);
    if (v.wbv) begin
      chk($sformatf("v%0d_wb_rd", idx), o_wb_rd, v.rd);
      chk($sformatf("v%0d_wb_data", idx), o_wb_data, v.data);
    end
    chk($sformatf("v%0d_writes", idx), wr_cycles - w0, v.writes);
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_idle_done", idx), o_done, 32'd0);
    chk($sformatf("v%0d_idle_ready", idx), o_ready, 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : test
    int t0, t1, t2, w0, n;
    //           op     addr          wdata          rd    exc   wbv   data           writes
    vecs[0]  = '{3'd7, 32'h0000_0010, 32'hDEADBEEF, 5'd0,  1'b0, 1'b0, 32'h0,         1};
    vecs[1]  = '{3'd2, 32'h0000_0010, 32'h0,        5'd5,  1'b0, 1'b1, 32'hDEADBEEF,  0};
    vecs[2]  = '{3'd5, 32'h0000_0020, 32'h0000_0080, 5'd0, 1'b0, 1'b0, 32'h0,         1};
    vecs[3]  = '{3'd0, 32'h0000_0020, 32'h0,        5'd1,  1'b0, 1'b1, 32'hFFFFFF80,  0};
    vecs[4]  = '{3'd3, 32'h0000_0020, 32'h0,        5'd2,  1'b0, 1'b1, 32'h00000080,  0};
    vecs[5]  = '{3'd1, 32'h0000_0021, 32'h0,        5'd3,  1'b1, 1'b0, 32'h00000021,  0};
    vecs[6]  = '{3'd2, 32'h0000_0FFE, 32'h0,        5'd4,  1'b1, 1'b0, 32'h00000FFE,  0};
    vecs[7]  = '{3'd7, 32'h0000_0FFC, 32'h11223344, 5'd0,  1'b0, 1'b0, 32'h0,         1};
    vecs[8]  = '{3'd2, 32'h0000_0FFC, 32'h0,        5'd9,  1'b0, 1'b1, 32'h11223344,  0};
    vecs[9]  = '{3'd7, 32'hFFFF_FFFC, 32'h55667788, 5'd0,  1'b1, 1'b0, 32'hFFFFFFFC,  0};
    vecs[10] = '{3'd6, 32'h0000_0030, 32'h1234ABCD, 5'd0,  1'b0, 1'b0, 32'h0,         1};
    vecs[11] = '{3'd1, 32'h0000_0030, 32'h0,        5'd10, 1'b0, 1'b1, 32'hFFFFABCD,  0};
    vecs[12] = '{3'd4, 32'h0000_0030, 32'h0,        5'd11, 1'b0, 1'b1, 32'h0000ABCD,  0};
    vecs[13] = '{3'd0, 32'h0000_0013, 32'h0,        5'd12, 1'b0, 1'b1, 32'hFFFFFFEF,  0};
    vecs[14] = '{3'd5, 32'h0000_1000, 32'h0000_00AA, 5'd0, 1'b1, 1'b0, 32'h00001000,  0};
    vecs[15] = '{3'd3, 32'h0000_0FFF, 32'h0,        5'd13, 1'b0, 1'b1, 32'h00000044,  0};

    // Reset state
    #1 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_ready", o_ready, 32'd0);
    chk("rst_done", o_done, 32'd0);
    chk("rst_outs", {26'd0, o_ram_insize, o_ram_outsize}, 32'd0);
    chk("rst_wb_data", o_wb_data, 32'd0);
    chk("rst_ram_addr", o_ram_addr, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", o_ready, 32'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

    chk("mem_sw_0x10", {mem[16], mem[17], mem[18], mem[19]}, 32'hDEADBEEF);
    chk("mem_nowrap_0xffc", {mem[4092], mem[4093], mem[4094], mem[4095]}, 32'h11223344);
    chk("mem_0x21_untouched", {24'd0, mem[33]}, 32'd0);

    // Stall: RESP held 5 cycles, new request ignored meanwhile
    i_stall = 1'b1;
    w0 = wr_cycles;
    issue(3'd2, 32'h10, 32'h0, 5'd7, t0);
    i_op    = 3'd7;
    i_addr  = 32'h40;
    i_wdata = 32'h99999999;
    i_rd    = 5'd3;
    @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d_done", k), o_done, 32'd1);
      chk($sformatf("stall%0d_data", k), o_wb_data, 32'hDEADBEEF);
      chk($sformatf("stall%0d_rd", k), o_wb_rd, 32'd7);
      chk($sformatf("stall%0d_ready", k), o_ready, 32'd0);
      if (k == 4) i_stall = 1'b0;
      @(posedge clk);
      #1;
    end
    chk("stall_exit_done", o_done, 32'd0);
    chk("stall_exit_ready", o_ready, 32'd1);
    i_valid = 1'b0;
    chk("stall_no_write", wr_cycles - w0, 32'd0);
    @(posedge clk);
    #1;
    chk("stall_not_accepted", o_ready, 32'd1);
    chk("stall_mem_0x40", {mem[64], mem[65], mem[66], mem[67]}, 32'd0);

    // Reset during a store's ACCESS cycle aborts the write
    w0 = wr_cycles;
    issue(3'd7, 32'h50, 32'hCAFEF00D, 5'd0, t0);
    i_valid = 1'b0;
    chk("rstacc_outsize_before", o_ram_outsize, 32'd4);
    #1 rst = 1'b1;
    #1;
    chk("rstacc_outsize", o_ram_outsize, 32'd0);
    chk("rstacc_ready", o_ready, 32'd0);
    #1 rst = 1'b0;
    #1;
    chk("rstacc_ready_after", o_ready, 32'd1);
    chk("rstacc_addr_cleared", o_ram_addr, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rstacc_mem", {mem[80], mem[81], mem[82], mem[83]}, 32'd0);
    chk("rstacc_writes", wr_cycles - w0, 32'd0);
    chk("rstacc_done", o_done, 32'd0);

    // Back-to-back requests with i_valid held high
    w0 = wr_cycles;
    issue(3'd5, 32'h60, 32'h11, 5'd0, t0);
    issue(3'd5, 32'h61, 32'h22, 5'd0, t1);
    issue(3'd0, 32'h60, 32'h0, 5'd4, t2);
    i_valid = 1'b0;
    chk("b2b_gap1", t1 - t0, 32'd3);
    chk("b2b_gap2", t2 - t1, 32'd3);
    n = 0;
    while (!o_done && n < 5) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("b2b_lat", n, 32'd1);
    chk("b2b_lb_data", o_wb_data, 32'h00000011);
    chk("b2b_writes", wr_cycles - w0, 32'd2);
    chk("b2b_mem", {16'd0, mem[96], mem[97]}, 32'h00001122);
    @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lsu_stage.md
LSU_STAGE -- requirements
Module: lsu_stage

Interface
REQ-001 Parameter: none; memory bound SHALL be `MEM_SIZE from defs.v (bytes).
REQ-002 i_clk  in  1  single clock; all state updates on posedge.
REQ-003 i_rst  in  1  reset, asynchronous, active-high.
REQ-004 i_valid  in  1  load/store request valid from execute stage.
REQ-005 o_ready  out  1  stage can accept a request this cycle.
REQ-006 i_op  in  3  0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU, 5 SB, 6 SH, 7 SW.
REQ-007 i_addr  in  32  effective byte address.
REQ-008 i_wdata  in  32  store data, right-aligned.
REQ-009 i_rd  in  5  load destination register tag.
REQ-010 o_ram_addr  out  32  to ram address port.
REQ-011 o_ram_insize  out  3  to ram read size (1/2/4 bytes, 0 = none).
REQ-012 o_ram_insign  out  1  to ram read sign-extend select.
REQ-013 o_ram_outsize  out  3  to ram write size (1/2/4, 0 = no write).
REQ-014 o_ram_data  out  32  to ram write data.
REQ-015 i_ram_data  in  32  from ram read data (combinational in ram).
REQ-016 i_stall  in  1  writeback cannot accept; hold response.
REQ-017 o_done  out  1  request completed (load, store or exception).
REQ-018 o_wb_valid  out  1  o_wb_rd/o_wb_data carry a load result.
REQ-019 o_wb_rd  out  5  load destination tag.
REQ-020 o_wb_data  out  32  load result, already sign/zero-extended.
REQ-021 o_exc  out  1  address error (misaligned or out of range).
REQ-022 o_badaddr  out  32  faulting address when o_exc=1.

Function
REQ-023 FSM states IDLE, ACCESS, RESP; o_ready=1 only in IDLE and i_rst=0.
REQ-024 IDLE: i_valid&o_ready at edge -> latch op, addr, wdata, rd; go ACCESS if address legal, else RESP with exception.
REQ-025 Legal: size = 1 (op 0,3,5), 2 (op 1,4,6), 4 (op 2,7); addr mod size == 0 and addr+size <= `MEM_SIZE (33-bit compare, no wrap).
REQ-026 ACCESS lasts exactly one cycle; o_ram_addr = latched addr throughout all states.
REQ-027 ACCESS load: o_ram_insize=size, o_ram_insign=1 for op 0,1,2 and 0 for op 3,4; o_ram_outsize=0; i_ram_data registered into o_wb_data at end of ACCESS.
REQ-028 ACCESS store: o_ram_outsize=size, o_ram_insize=0, o_ram_data=latched wdata; ram commits at end of ACCESS edge.
REQ-029 Outside ACCESS: o_ram_insize=0, o_ram_outsize=0, o_ram_insign=0 — no spurious write possible.
REQ-030 RESP: o_done=1; o_wb_valid=1 for legal loads only; o_exc=1 and o_badaddr=addr for illegal; stores give o_wb_valid=0, o_exc=0.
REQ-031 RESP held with outputs stable while i_stall=1; RESP -> IDLE at first edge with i_stall=0.
REQ-032 Latency: accept edge N, ACCESS cycle N+1, RESP from edge N+2; exception: RESP from edge N+1. Throughput max 1 per 3 cycles.
REQ-033 i_valid ignored when o_ready=0; requester must hold request until accepted.
REQ-034 o_done, o_wb_valid, o_exc SHALL be 0 in IDLE and ACCESS.

Reset
REQ-035 i_rst=1 forces IDLE immediately (asynchronously); all outputs 0 except o_ready, which is 0 while i_rst=1 and 1 in IDLE afterwards.
REQ-036 Reset asserted during ACCESS SHALL drop o_ram_outsize to 0 before the next edge — store aborted, memory unchanged.
REQ-037 Latched request registers and o_wb_data/o_badaddr cleared to 0 on reset.

Verification
REQ-038 SW addr 0x10 wdata 0xDEADBEEF, then LW 0x10 rd 5 -> RESP: o_wb_valid=1, o_wb_rd=5, o_wb_data=0xDEADBEEF; mem[0x10..0x13]=DE,AD,BE,EF.
REQ-039 SB 0x20 wdata 0x80; LB 0x20 -> 0xFFFFFF80; LBU 0x20 -> 0x00000080; LH 0x21 -> o_exc=1, o_badaddr=0x21, no ram access.
REQ-040 LW at `MEM_SIZE-2 -> o_exc=1, o_wb_valid=0; SW at 0xFFFFFFFC -> o_exc=1, memory unchanged (no wrap).
REQ-041 LW accepted with i_stall=1 for 4 cycles -> o_done/o_wb_data stable 5 cycles, o_ready=0, new i_valid ignored until IDLE.
REQ-042 SW accepted, i_rst pulsed during ACCESS -> o_ram_outsize=0 immediately, target bytes unchanged, o_ready=1 after reset release.
REQ-043 Back-to-back valid requests -> accepts spaced exactly 3 cycles apart; o_ram_outsize nonzero exactly one cycle per store.
